// File: rtl/ili9341_pkg.sv
// Command opcodes and FSM encodings shared by the ILI9341 bus receiver.
package ili9341_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_TEOFF   = 8'h34;
    localparam logic [7:0] CMD_TEON    = 8'h35;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    typedef enum logic [1:0] {ST_IDLE, ST_PARAM, ST_RAMWR} state_e;
    typedef enum logic [1:0] {PK_CASET, PK_PASET, PK_MADCTL} pkind_e;

endpackage

// File: rtl/ili9341_rx_sync.sv
// Brings the asynchronous 8080 write bus into clk: 3-stage sync, we_n rising-edge detect,
// then one register stage so the decoded byte lands 3 clk after the bus edge. No backpressure.
module ili9341_rx_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data,
    input  logic       lcd_we_n,
    input  logic       lcd_rs,
    output logic [7:0] byte_dat,
    output logic       rs_dat,
    output logic       byte_vld
);
    logic [2:0]       we_q, we_d;
    logic [2:0]       rs_q, rs_d;
    logic [2:0][7:0]  data_q, data_d;
    logic [7:0]       byte_q, byte_d;
    logic             rsb_q, rsb_d;
    logic             vld_q, vld_d;
    logic             we_rise;

    always_comb begin
        we_d    = {we_q[1:0], lcd_we_n};
        rs_d    = {rs_q[1:0], lcd_rs};
        data_d  = {data_q[1], data_q[0], lcd_data};
        we_rise = we_q[1] & ~we_q[2];
        vld_d   = we_rise;
        byte_d  = we_rise ? data_q[2] : byte_q;
        rsb_d   = we_rise ? rs_q[2] : rsb_q;
    end

    // Chain resets to the idle-high strobe level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 3'b111;
            rs_q   <= '0;
            data_q <= '0;
            byte_q <= '0;
            rsb_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            rs_q   <= rs_d;
            data_q <= data_d;
            byte_q <= byte_d;
            rsb_q  <= rsb_d;
            vld_q  <= vld_d;
        end
    end

    assign byte_dat = byte_q;
    assign rs_dat   = rsb_q;
    assign byte_vld = vld_q;
endmodule

// File: rtl/ili9341_rx.sv
// ILI9341 8080 write-bus receiver: decodes commands, tracks the window, emits RGB565 pixel writes.
// Bus edge to pix_valid/cmd_strobe = 4 clk; no backpressure. Define ILI_RX_TE_EN for the TE pulse.
module ili9341_rx
    import ili9341_pkg::*;
#(
    parameter int WIDTH        = 240,
    parameter int HEIGHT       = 320,
    parameter int FRAME_CYCLES = 833333,
    parameter int TE_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  lcd_data,
    input  logic        lcd_we_n,
    input  logic        lcd_rs,
    output logic        lcd_fmark,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_byte,
    output logic [7:0]  madctl,
    output logic        disp_on,
    output logic        sleep_out
);
    localparam logic [8:0] XE_RST = 9'(WIDTH - 1);
    localparam logic [8:0] YE_RST = 9'(HEIGHT - 1);

    logic [7:0] rx_byte;
    logic       rx_rs, rx_vld;

    ili9341_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .lcd_data (lcd_data),
        .lcd_we_n (lcd_we_n),
        .lcd_rs   (lcd_rs),
        .byte_dat (rx_byte),
        .rs_dat   (rx_rs),
        .byte_vld (rx_vld)
    );

    state_e      state_q, state_d;
    pkind_e      kind_q, kind_d;
    logic [1:0]  idx_q, idx_d;
    logic        s_hi_q, s_hi_d, e_hi_q, e_hi_d;
    logic [7:0]  s_lo_q, s_lo_d;
    logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [8:0]  px_q, px_d, py_q, py_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        pix_valid_q, pix_valid_d;
    logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d, madctl_q, madctl_d;
    logic        disp_on_q, disp_on_d, sleep_out_q, sleep_out_d;
    logic        te_en_q, te_en_d;
    logic [8:0]  xe_eff, ye_eff;

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        idx_d        = idx_q;
        s_hi_d       = s_hi_q;
        s_lo_d       = s_lo_q;
        e_hi_d       = e_hi_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        px_d         = px_q;
        py_d         = py_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        cmd_strobe_d = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        madctl_d     = madctl_q;
        disp_on_d    = disp_on_q;
        sleep_out_d  = sleep_out_q;
        te_en_d      = te_en_q;
        // An inverted window collapses to its start coordinate.
        xe_eff       = (xe_q < xs_q) ? xs_q : xe_q;
        ye_eff       = (ye_q < ys_q) ? ys_q : ye_q;

        if (rx_vld && !rx_rs) begin
            cmd_strobe_d = 1'b1;
            cmd_byte_d   = rx_byte;
            state_d      = ST_IDLE;
            idx_d        = 2'd0;
            phase_d      = 1'b0;
            case (rx_byte)
                CMD_CASET:   begin state_d = ST_PARAM; kind_d = PK_CASET;  end
                CMD_PASET:   begin state_d = ST_PARAM; kind_d = PK_PASET;  end
                CMD_MADCTL:  begin state_d = ST_PARAM; kind_d = PK_MADCTL; end
                CMD_RAMWR:   begin state_d = ST_RAMWR; px_d = xs_q; py_d = ys_q; end
                CMD_RAMWRC:  begin state_d = ST_RAMWR; phase_d = phase_q; end
                CMD_DISPON:  disp_on_d = 1'b1;
                CMD_DISPOFF: disp_on_d = 1'b0;
                CMD_SLPOUT:  sleep_out_d = 1'b1;
                CMD_SLPIN:   sleep_out_d = 1'b0;
                CMD_SWRESET: begin
                    xs_d = '0; xe_d = XE_RST; ys_d = '0; ye_d = YE_RST;
                    px_d = '0; py_d = '0;
                    pix_x_d = '0; pix_y_d = '0; pix_data_d = '0;
                    madctl_d = '0; disp_on_d = 1'b0; sleep_out_d = 1'b0;
                    te_en_d = 1'b0;
                end
`ifdef ILI_RX_TE_EN
                CMD_TEON:    te_en_d = 1'b1;
                CMD_TEOFF:   te_en_d = 1'b0;
`endif
                default: ;
            endcase
        end else if (rx_vld) begin
            case (state_q)
                ST_PARAM: begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: begin
                            s_hi_d = rx_byte[0];
                            if (kind_q == PK_MADCTL) begin
                                madctl_d = rx_byte;
                                state_d  = ST_IDLE;
                            end
                        end
                        2'd1: s_lo_d = rx_byte;
                        2'd2: e_hi_d = rx_byte[0];
                        default: begin
                            state_d = ST_IDLE;
                            if (kind_q == PK_CASET) begin
                                xs_d = {s_hi_q, s_lo_q};
                                xe_d = {e_hi_q, rx_byte};
                            end else begin
                                ys_d = {s_hi_q, s_lo_q};
                                ye_d = {e_hi_q, rx_byte};
                            end
                        end
                    endcase
                end
                ST_RAMWR: begin
                    if (!phase_q) begin
                        hi_d    = rx_byte;
                        phase_d = 1'b1;
                    end else begin
                        phase_d     = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_x_d     = px_q;
                        pix_y_d     = py_q;
                        pix_data_d  = {hi_q, rx_byte};
                        if (px_q == xe_eff) begin
                            px_d = xs_q;
                            py_d = (py_q == ye_eff) ? ys_q : py_q + 9'd1;
                        end else begin
                            px_d = px_q + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            kind_q       <= PK_CASET;
            idx_q        <= '0;
            s_hi_q       <= 1'b0;
            s_lo_q       <= '0;
            e_hi_q       <= 1'b0;
            xs_q         <= '0;
            xe_q         <= XE_RST;
            ys_q         <= '0;
            ye_q         <= YE_RST;
            px_q         <= '0;
            py_q         <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_data_q   <= '0;
            cmd_strobe_q <= 1'b0;
            cmd_byte_q   <= '0;
            madctl_q     <= '0;
            disp_on_q    <= 1'b0;
            sleep_out_q  <= 1'b0;
            te_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            idx_q        <= idx_d;
            s_hi_q       <= s_hi_d;
            s_lo_q       <= s_lo_d;
            e_hi_q       <= e_hi_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            px_q         <= px_d;
            py_q         <= py_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_byte_q   <= cmd_byte_d;
            madctl_q     <= madctl_d;
            disp_on_q    <= disp_on_d;
            sleep_out_q  <= sleep_out_d;
            te_en_q      <= te_en_d;
        end
    end

`ifdef ILI_RX_TE_EN
    localparam int FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    logic [FC_W-1:0] frame_q, frame_d;

    always_comb begin
        frame_d = (frame_q == FC_W'(FRAME_CYCLES - 1)) ? '0 : frame_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= '0;
        else        frame_q <= frame_d;
    end

    assign lcd_fmark = te_en_q && (frame_q < FC_W'(TE_CYCLES));
`else
    assign lcd_fmark = 1'b0;
`endif

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_data   = pix_data_q;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_byte   = cmd_byte_q;
    assign madctl     = madctl_q;
    assign disp_on    = disp_on_q;
    assign sleep_out  = sleep_out_q;
endmodule

// File: tb/tb_ili9341_rx.sv
// Scoreboard bench for ili9341_rx: stimulus pushes expected pixels/commands with their due cycle,
// a negedge monitor pops and compares whenever pix_valid or cmd_strobe is seen.
module tb_ili9341_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  lcd_data = 8'h00;
    logic        lcd_we_n = 1'b1;
    logic        lcd_rs = 1'b0;
    logic        lcd_fmark, pix_valid, cmd_strobe, disp_on, sleep_out;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    logic [7:0]  cmd_byte, madctl;

    ili9341_rx #(.WIDTH(240), .HEIGHT(320), .FRAME_CYCLES(100), .TE_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_we_n(lcd_we_n), .lcd_rs(lcd_rs),
        .lcd_fmark(lcd_fmark), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte), .madctl(madctl),
        .disp_on(disp_on), .sleep_out(sleep_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [8:0] x; logic [8:0] y; logic [15:0] d; int due; } pix_exp_t;
    typedef struct { logic [7:0] b; int due; } cmd_exp_t;
    pix_exp_t pq[$];
    cmd_exp_t cq[$];

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin
        if (rst_n && pix_valid) begin
            vecs++;
            if (pq.size() == 0) begin
                errs++;
                $display("FAIL pix_unexpected: got (%0d,%0d)=%h @%0d, expected none", pix_x, pix_y, pix_data, cyc);
            end else begin
                pix_exp_t e;
                e = pq.pop_front();
                if (pix_x !== e.x || pix_y !== e.y || pix_data !== e.d || cyc != e.due) begin
                    errs++;
                    $display("FAIL pix: got (%0d,%0d)=%h @%0d, expected (%0d,%0d)=%h @%0d",
                             pix_x, pix_y, pix_data, cyc, e.x, e.y, e.d, e.due);
                end
            end
        end
        if (rst_n && cmd_strobe) begin
            vecs++;
            if (cq.size() == 0) begin
                errs++;
                $display("FAIL cmd_unexpected: got %h @%0d, expected none", cmd_byte, cyc);
            end else begin
                cmd_exp_t c;
                c = cq.pop_front();
                if (cmd_byte !== c.b || cyc != c.due) begin
                    errs++;
                    $display("FAIL cmd: got %h @%0d, expected %h @%0d", cmd_byte, cyc, c.b, c.due);
                end
            end
        end
    end

    task automatic send_byte(input logic rs, input logic [7:0] b, input bit exp_cmd,
                             input bit exp_pix, input int x, input int y, input logic [15:0] d);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_data = b;
        lcd_we_n = 1'b0;
        repeat (3) @(negedge clk);
        lcd_we_n = 1'b1;
        if (exp_cmd) cq.push_back('{b: b, due: cyc + 4});
        if (exp_pix) pq.push_back('{x: 9'(x), y: 9'(y), d: d, due: cyc + 4});
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(1'b0, b, 1'b1, 1'b0, 0, 0, 16'h0);
    endtask

    task automatic par(input logic [7:0] b);
        send_byte(1'b1, b, 1'b0, 1'b0, 0, 0, 16'h0);
    endtask

    task automatic pix(input int x, input int y, input logic [15:0] d);
        send_byte(1'b1, d[15:8], 1'b0, 1'b0, 0, 0, 16'h0);
        send_byte(1'b1, d[7:0], 1'b0, 1'b1, x, y, d);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return {9'd0, lcd_fmark, pix_valid, pix_x, pix_y, pix_data, cmd_strobe, cmd_byte,
                madctl, disp_on, sleep_out};
    endfunction

    int win_x[7] = '{10, 11, 12, 10, 11, 12, 10};
    int win_y[7] = '{5, 5, 5, 6, 6, 6, 5};

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_outputs", all_outs(), 64'd0);

        // Default window: first two pixels land at (0,0),(1,0), each due 4 clk after its edge.
        cmd(8'h2C);
        pix(0, 0, 16'h1234);
        pix(1, 0, 16'hABCD);

        // Window 10..12 x 5..6, seven pixels (last wraps), then RAMWRC continues.
        cmd(8'h2A); par(8'h00); par(8'h0A); par(8'h00); par(8'h0C);
        cmd(8'h2B); par(8'h00); par(8'h05); par(8'h00); par(8'h06);
        cmd(8'h2C);
        for (int i = 0; i < 7; i++) pix(win_x[i], win_y[i], 16'(16'h1000 + i));
        cmd(8'h3C);
        pix(11, 5, 16'hBEEF);

        // Half pixel then DISPON: no pixel, display on.
        cmd(8'h2C); par(8'h55); cmd(8'h29);
        settle();
        check("disp_on_set", 64'(disp_on), 64'd1);
        par(8'h77);
        cmd(8'h11); settle();
        check("sleep_out_set", 64'(sleep_out), 64'd1);
        cmd(8'h10); settle();
        check("sleep_out_clr", 64'(sleep_out), 64'd0);
        cmd(8'h36); par(8'hA8); par(8'h77); settle();
        check("madctl", 64'(madctl), 64'hA8);
        cmd(8'h00); par(8'h13); par(8'h57); settle();
        check("madctl_after_unknown", 64'(madctl), 64'hA8);

        // Inverted column window collapses to x=20; a truncated CASET leaves it intact.
        cmd(8'h2A); par(8'h00); par(8'h14); par(8'h00); par(8'h03);
        cmd(8'h2C);
        pix(20, 5, 16'h0F0F);
        pix(20, 6, 16'hF0F0);
        pix(20, 5, 16'h5A5A);
        cmd(8'h2A); par(8'h00); par(8'h01); par(8'h00);
        cmd(8'h2C);
        pix(20, 5, 16'hC3C3);

        // Tearing-effect output.
        cmd(8'h35); par(8'h00); settle();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lcd_fmark) n++;
        end
`ifdef ILI_RX_TE_EN
        check("fmark_high_cycles", 64'(n), 64'd10);
`else
        check("fmark_tied_low", 64'(n), 64'd0);
`endif
        cmd(8'h34); settle();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lcd_fmark) n++;
        end
        check("fmark_off_cycles", 64'(n), 64'd0);

        // SWRESET restores window and mode registers.
        cmd(8'h01); settle();
        check("swreset_modes", {61'd0, disp_on, madctl == 8'h00, sleep_out}, 64'd2);
        cmd(8'h2C);
        pix(0, 0, 16'h2468);
        pix(1, 0, 16'h1357);

        // Reset mid-RAMWR: outputs clear asynchronously, half pixel is lost.
        cmd(8'h29); cmd(8'h2C); par(8'h99);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cmd(8'h2C);
        pix(0, 0, 16'h8001);

        repeat (10) @(negedge clk);
        check("pix_queue_drained", 64'(pq.size()), 64'd0);
        check("cmd_queue_drained", 64'(cq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
